// File: rtl/spice_pkg.sv
// Shared FSM state type and width helpers for the SPICE branch blocks.
`ifndef W
`define W 16
`endif

package spice_pkg;

    typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

    localparam int SIG_W  = `W;
    localparam int DIFF_W = `W + 1;

    function automatic int prod_w(input int gw);
        return DIFF_W + gw;
    endfunction

    function automatic int cnt_w(input int gw);
        return (gw < 2) ? 1 : $clog2(gw + 1);
    endfunction

endpackage

// File: rtl/spice_serial_mul.sv
// Serial shift-add multiplier: signed difference times unsigned conductance,
// one conductance bit per enabled cycle, LSB first.
module spice_serial_mul
    import spice_pkg::*;
#(
    parameter int GW = 8
) (
    input  logic                             eclk,
    input  logic                             ereset,
    input  logic                             load,
    input  logic                             en,
    input  logic signed [DIFF_W-1:0]         diff,
    input  logic        [GW-1:0]             g,
    output logic signed [prod_w(GW)-1:0]     acc,
    output logic                             fin
);

    localparam int PW = prod_w(GW);
    localparam int CW = cnt_w(GW);

    logic signed [PW-1:0] dsh;
    logic        [GW-1:0] gsh;
    logic        [CW-1:0] cnt;

    always_ff @(posedge eclk) begin
        if (ereset) begin
            dsh <= '0;
            gsh <= '0;
            acc <= '0;
            cnt <= '0;
            fin <= 1'b0;
        end else if (load) begin
            dsh <= PW'(diff);
            gsh <= g;
            acc <= '0;
            cnt <= '0;
            fin <= 1'b0;
        end else if (en && !fin) begin
            // Operands shift instead of indexing, so bit k of g meets diff << k.
            if (gsh[0])
                acc <= acc + dsh;
            dsh <= dsh <<< 1;
            gsh <= gsh >> 1;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(GW - 1))
                fin <= 1'b1;
        end
    end

endmodule

// File: rtl/spice_branch_g.sv
// Conductance branch: i = floor((va - vb) * g / 2^SHIFT), ib = i, ia = -i for one cycle.
// Define SPICE_BRANCH_SAT_EN to clamp i to a symmetric range instead of wrapping.
`ifndef W
`define W 16
`endif

module spice_branch_g
    import spice_pkg::*;
#(
    parameter int GW    = 8,
    parameter int SHIFT = 8
) (
    input  logic                 eclk,
    input  logic                 ereset,
    input  logic                 step,
    input  logic signed [`W-1:0] va,
    input  logic signed [`W-1:0] vb,
    input  logic        [GW-1:0] g,
    output logic signed [`W-1:0] ia,
    output logic signed [`W-1:0] ib,
    output logic                 busy,
    output logic                 done
);

    localparam int PW = prod_w(GW);
    localparam logic signed [`W-1:0] IMAX = {1'b0, {(`W-1){1'b1}}};

    state_t                  state;
    logic                    load;
    logic                    fin;
    logic signed [DIFF_W-1:0] diff;
    logic signed [PW-1:0]    acc;
    logic signed [PW-1:0]    quo;
    logic signed [`W-1:0]    i_val;

    function automatic logic signed [`W-1:0] limit(input logic signed [PW-1:0] x);
`ifdef SPICE_BRANCH_SAT_EN
        // Symmetric clamp keeps -i representable.
        if (x > PW'(IMAX))
            return IMAX;
        else if (x < -PW'(IMAX))
            return -IMAX;
        else
            return `W'(x);
`else
        return `W'(x);
`endif
    endfunction

    assign load  = (state == IDLE) && step;
    assign diff  = DIFF_W'(va) - DIFF_W'(vb);
    assign quo   = acc >>> SHIFT;
    assign i_val = limit(quo);

    spice_serial_mul #(
        .GW(GW)
    ) u_mul (
        .eclk   (eclk),
        .ereset (ereset),
        .load   (load),
        .en     (state == MUL),
        .diff   (diff),
        .g      (g),
        .acc    (acc),
        .fin    (fin)
    );

    // MUL spans GW bit cycles plus one settle cycle, so done lands GW+1 edges after step.
    always_ff @(posedge eclk) begin
        if (ereset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            ia    <= '0;
            ib    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (step) begin
                        state <= MUL;
                        busy  <= 1'b1;
                    end
                end
                MUL: begin
                    if (fin) begin
                        state <= OUT;
                        done  <= 1'b1;
                        ib    <= i_val;
                        ia    <= -i_val;
                    end
                end
                OUT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    ia    <= '0;
                    ib    <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spice_branch_g.sv
// Directed bench for spice_branch_g (W=16); a GW=9 instance drives an integrating node.
module tb_spice_branch_g;

    logic               eclk;
    logic               ereset;
    logic               step;
    logic signed [15:0] va;
    logic signed [15:0] vb;
    logic        [7:0]  g;
    logic signed [15:0] ia;
    logic signed [15:0] ib;
    logic               busy;
    logic               done;

    logic               step2;
    logic signed [15:0] va2;
    logic signed [15:0] vb2;
    logic        [8:0]  g2;
    logic signed [15:0] ia2;
    logic signed [15:0] ib2;
    logic               busy2;
    logic               done2;

    int node;
    int n_assert;
    int n_fail;

    spice_branch_g #(.GW(8), .SHIFT(8)) dut (
        .eclk   (eclk),
        .ereset (ereset),
        .step   (step),
        .va     (va),
        .vb     (vb),
        .g      (g),
        .ia     (ia),
        .ib     (ib),
        .busy   (busy),
        .done   (done)
    );

    spice_branch_g #(.GW(9), .SHIFT(8)) dut2 (
        .eclk   (eclk),
        .ereset (ereset),
        .step   (step2),
        .va     (va2),
        .vb     (vb2),
        .g      (g2),
        .ia     (ia2),
        .ib     (ib2),
        .busy   (busy2),
        .done   (done2)
    );

    initial eclk = 1'b0;
    always #5 eclk = ~eclk;

    // Single-input integrating node fed by the second branch's ib.
    always_ff @(posedge eclk) begin
        if (ereset)
            node <= 0;
        else
            node <= node + int'(ib2);
    end

    task automatic tick();
        @(posedge eclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic eval(input string tag, input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic [7:0] gg, input logic signed [15:0] eib, input logic signed [15:0] eia);
        va = a; vb = b; g = gg; step = 1'b1;
        tick();
        step = 1'b0;
        chk({tag, "_busy_start"}, 32'(busy), 1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 2) begin
                va = ~a; vb = a; g = ~gg;
            end
            chk({tag, "_done_early"}, 32'(done), 0);
            chk({tag, "_ib_early"}, ib, 0);
        end
        tick();
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_ib"}, ib, eib);
        chk({tag, "_ia"}, ia, eia);
        chk({tag, "_busy_out"}, 32'(busy), 1);
        tick();
        chk({tag, "_done_after"}, 32'(done), 0);
        chk({tag, "_ib_after"}, ib, 0);
        chk({tag, "_ia_after"}, ia, 0);
        chk({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        int ndone;
        int dcyc;
        int dib;

        n_assert = 0;
        n_fail   = 0;
        ereset = 1'b1; step = 1'b0; va = '0; vb = '0; g = '0;
        step2 = 1'b0; va2 = '0; vb2 = '0; g2 = '0;
        tick();
        tick();
        chk("rst_ia", ia, 0);
        chk("rst_ib", ib, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        ereset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        eval("nominal", 16'sd1000, 16'sd200, 8'd128, 16'sd400, -16'sd400);
        eval("floor_m256", 16'sd0, 16'sd256, 8'd1, -16'sd1, 16'sd1);
        eval("floor_m1", 16'sd0, 16'sd1, 8'd1, -16'sd1, 16'sd1);
        eval("floor_p1", 16'sd1, 16'sd0, 8'd1, 16'sd0, 16'sd0);
        eval("g_zero", 16'sd1000, 16'sd200, 8'd0, 16'sd0, 16'sd0);
        eval("neg_diff", -16'sd300, 16'sd500, 8'd200, -16'sd625, 16'sd625);
`ifdef SPICE_BRANCH_SAT_EN
        eval("overflow", 16'sd32767, -16'sd32768, 8'd255, 16'sd32767, -16'sd32767);
`else
        eval("overflow", 16'sd32767, -16'sd32768, 8'd255, -16'sd257, 16'sd257);
`endif

        // Second step while busy is ignored.
        va = 16'sd1000; vb = 16'sd200; g = 8'd128; step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        va = 16'sd5000; step = 1'b1;
        tick();
        step = 1'b0;
        ndone = 0; dcyc = 0; dib = 0;
        for (int c = 4; c <= 20; c++) begin
            tick();
            if (done) begin
                ndone++;
                dcyc = c;
                dib = int'(ib);
            end
        end
        chk("busy_step_count", ndone, 1);
        chk("busy_step_cycle", dcyc, 9);
        chk("busy_step_ib", dib, 400);

        // Step during the done cycle is ignored.
        va = 16'sd1000; vb = 16'sd200; g = 8'd128; step = 1'b1;
        tick();
        step = 1'b0;
        repeat (8) tick();
        tick();
        chk("out_step_done", 32'(done), 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("out_step_busy", 32'(busy), 0);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) ndone++;
        end
        chk("out_step_count", ndone, 0);

        // Reset in the fourth MUL cycle aborts the evaluation.
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (3) tick();
        ereset = 1'b1;
        tick();
        ereset = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        ndone = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort_count", ndone, 0);
        eval("post_abort", 16'sd1000, 16'sd200, 8'd128, 16'sd400, -16'sd400);

        // Reset wins over a simultaneous step.
        ereset = 1'b1; step = 1'b1;
        tick();
        ereset = 1'b0; step = 1'b0;
        chk("rst_prio_busy", 32'(busy), 0);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) ndone++;
        end
        chk("rst_prio_count", ndone, 0);

        // Integrating node driven by a branch with g=0, then g=1.0.
        chk("node_start", node, 0);
        va2 = 16'sd10; vb2 = 16'sd0; g2 = 9'd0;
        for (int p = 0; p < 3; p++) begin
            step2 = 1'b1;
            tick();
            step2 = 1'b0;
            repeat (11) tick();
            chk("node_g0", node, 0);
        end
        g2 = 9'd256;
        for (int p = 0; p < 3; p++) begin
            step2 = 1'b1;
            tick();
            step2 = 1'b0;
            repeat (11) tick();
            chk("node_g256", node, 10 * (p + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spice_branch_g.md
SPICE_BRANCH_G -- requirements
Module: spice_branch_g

Interface
REQ-001 The block SHALL use parameter GW, default 8: unsigned conductance width in bits.
REQ-002 The block SHALL use parameter SHIFT, default 8: number of fractional bits in the conductance.
REQ-003 The block SHALL take signal width W from the shared `W define in common.h.
REQ-004 The block SHALL have port eclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port ereset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port step, input, 1 bit: one-cycle pulse that starts one evaluation.
REQ-007 The block SHALL have ports va and vb, input, signed W each: terminal node voltages.
REQ-008 The block SHALL have port g, input, unsigned GW: branch conductance.
REQ-009 The block SHALL have ports ia and ib, output, signed W each: currents injected into nodes a and b.
REQ-010 The block SHALL have port busy, output, 1 bit: evaluation in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when ia and ib are valid.

Function
REQ-012 The block SHALL compute branch current i = floor(((va - vb) * g) / 2^SHIFT).
- The subtraction SHALL be done at W+1 bits.
- The product SHALL be W+1+GW bits.
- The shift SHALL be arithmetic, which gives floor rounding.
REQ-013 The block SHALL drive ib = i and ia = -i in the done cycle only; both SHALL be 0 in every other cycle.
- This ensures attached integrating nodes accumulate exactly once per evaluation.
REQ-014 The FSM SHALL have states IDLE, MUL and OUT.
- IDLE -> MUL on step: capture va - vb and g, clear the accumulator, reset the bit counter.
- MUL: one g bit per cycle, LSB first; add the shifted difference when the bit is 1; stay for exactly GW cycles.
- MUL -> OUT after bit GW-1.
- OUT -> IDLE after one cycle.
REQ-015 busy SHALL be 1 in MUL and OUT; done SHALL be 1 in OUT only.
REQ-016 With step sampled high at edge k, done SHALL be high in the cycle following edge k+GW+1.
REQ-017 A step while busy=1 SHALL be ignored; captured operands SHALL NOT change mid-evaluation.
REQ-018 A step in the OUT cycle SHALL be ignored; a new step is accepted only in IDLE.
REQ-019 If va, vb or g change after capture, the in-flight result SHALL NOT be affected.
REQ-020 When g = 0, the block SHALL still take the full GW+1 cycles and produce ia = ib = 0 with done asserted.

Reset
REQ-021 Reset SHALL act as follows:
- On ereset at any edge, state SHALL become IDLE.
- Accumulator, counter and captured operands SHALL clear.
- ia, ib, busy and done SHALL be 0 in the following cycle.
REQ-022 Reset during MUL or OUT SHALL abort the evaluation with no done pulse.
REQ-023 ereset SHALL take priority over a simultaneous step.

Configuration
REQ-024 The block SHALL support macro SPICE_BRANCH_SAT_EN.
- Defined: i SHALL be clamped to [-(2^(W-1)-1), 2^(W-1)-1], so -i is always representable.
- Undefined: i SHALL be the low W bits of the shifted product (two's-complement wrap), and ia = -i SHALL also wrap.

Structure
REQ-025 Package spice_pkg SHALL hold the FSM state enum and derived width constants (diff width, product width, counter width).
- W SHALL remain in common.h.
REQ-026 The serial shift-add multiplier (counter, accumulator, bit select) SHALL be sub-module spice_serial_mul.
- spice_branch_g SHALL keep the FSM, the negation and the saturation.

Verification (W=16, GW=8, SHIFT=8)
REQ-027 Nominal case: va=1000, vb=200, g=128, step -> ib=400 and ia=-400, with done exactly 9 cycles after step; ia and ib SHALL be 0 before and after that cycle.
REQ-028 Floor rounding:
- va=0, vb=256, g=1 -> ib=-1, ia=1.
- va=0, vb=1, g=1 -> ib=-1, ia=1.
- va=1, vb=0, g=1 -> ib=0, ia=0.
REQ-029 Overflow: va=32767, vb=-32768, g=255.
- SAT_EN defined -> ib=32767, ia=-32767.
- SAT_EN undefined -> ib=-257, ia=257.
REQ-030 Step while busy: step, then step again 3 cycles later with different va -> exactly one done, with the first operands' result.
REQ-031 Reset mid-operation: ereset at cycle 4 of MUL -> no done pulse, busy=0 next cycle; a subsequent step gives the correct result at nominal latency.
REQ-032 Integration with a node: a branch of g=0 with step every 10 cycles driving a single-input integrating node -> node voltage stays 0; with g=256 and va - vb = 10, the node rises by exactly 10 per step.
